// File: rtl/kyber_pkg.sv
// ============================================================================
// Module : kyber_pkg
// Brief  : Shared Kyber constants, coefficient type and CBD sampler states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package kyber_pkg;
  localparam int KYBER_N   = 256;
  localparam int KYBER_Q   = 3329;
  localparam int KYBER_ETA = 2;

  typedef logic [15:0] coeff_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } cbd_state_t;
endpackage

`default_nettype wire

// File: rtl/cbd_nibble.sv
// ============================================================================
// Module : cbd_nibble
// Brief  : Combinational eta=2 CBD of one nibble; POLY_CBD_SIGNED_OUT_EN
//          selects signed output instead of canonical mod-Q encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cbd_nibble
  import kyber_pkg::*;
#(
  parameter int Q = KYBER_Q
) (
  input  logic [3:0]  nib_i,
  output logic [15:0] coeff_o
);

  logic [1:0] w_x;
  logic [1:0] w_y;

  assign w_x = {1'b0, nib_i[0]} + {1'b0, nib_i[1]};
  assign w_y = {1'b0, nib_i[2]} + {1'b0, nib_i[3]};

`ifdef POLY_CBD_SIGNED_OUT_EN
  logic signed [2:0] w_d;

  assign w_d     = $signed({1'b0, w_x}) - $signed({1'b0, w_y});
  assign coeff_o = {{13{w_d[2]}}, w_d};
`else
  // Negative d folds to Q-|d| so the result is always canonical in [0, Q-1].
  always_comb begin
    coeff_o = 16'd0;
    if (w_x >= w_y) begin
      coeff_o = {14'd0, w_x - w_y};
    end else begin
      coeff_o = 16'(Q) - {14'd0, w_y - w_x};
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/poly_cbd_sampler.sv
// ============================================================================
// Module : poly_cbd_sampler
// Brief  : Streams 128 PRF bytes into 256 CBD(eta=2) coefficients held in
//          parallel until acknowledged. Option: POLY_CBD_SIGNED_OUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module poly_cbd_sampler
  import kyber_pkg::*;
#(
  parameter int N    = KYBER_N,
  parameter int Q    = KYBER_Q,
  parameter int IN_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [15:0]     out [N],
  output logic            valid,
  input  logic            out_ack
);

  localparam int BEATS = 1024 / IN_W;
  localparam int CPB   = IN_W / 4;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  cbd_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             valid_q, valid_d;
  logic [15:0]      coeff_q [N];
  logic [15:0]      w_nib_coeff [CPB];
  logic             w_accept;

  generate
    for (genvar j = 0; j < CPB; j++) begin : g_nib
      cbd_nibble #(
        .Q (Q)
      ) u_nib (
        .nib_i   (in_data[4*j +: 4]),
        .coeff_o (w_nib_coeff[j])
      );
    end
  endgenerate

  // in_ready_q is high exactly while in FILL, so it doubles as the state qualifier.
  assign w_accept = in_valid & in_ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (w_accept) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    in_ready_d = (state_d == FILL);
    valid_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        coeff_q[i] <= '0;
      end
    end else if (w_accept) begin
      for (int b = 0; b < BEATS; b++) begin
        if (cnt_q == CNT_W'(b)) begin
          for (int m = 0; m < CPB; m++) begin
            coeff_q[b*CPB + m] <= w_nib_coeff[m];
          end
        end
      end
    end
  end

  assign in_ready = in_ready_q;
  assign valid    = valid_q;
  assign out      = coeff_q;

endmodule

`default_nettype wire
